mmio_periph: RTL and testbench

MMIO_PERIPH -- requirements
Module: mmio_periph

---
 rtl/periph_pkg.sv | 21 ++
 rtl/mmio_periph_uart_tx.sv | 90 +++++++++
 rtl/mmio_periph.sv | 100 ++++++++++
 tb/tb_mmio_periph.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/periph_pkg.sv
// Shared definitions for the memory-mapped display/timer/UART peripheral.
package periph_pkg;

  localparam logic [11:0] OFF_DISPLAY     = 12'h000;
  localparam logic [11:0] OFF_TIMER       = 12'h004;
  localparam logic [11:0] OFF_UART_DATA   = 12'h008;
  localparam logic [11:0] OFF_UART_STATUS = 12'h00C;

  localparam int STAT_FULL     = 0;
  localparam int STAT_EMPTY    = 1;
  localparam int STAT_BUSY     = 2;
  localparam int STAT_OVERFLOW = 3;

  typedef enum logic [1:0] {
    UART_IDLE,
    UART_START,
    UART_DATA,
    UART_STOP
  } uart_state_e;

endpackage

// File: rtl/mmio_periph_uart_tx.sv
// 8N1 UART transmitter: takes one byte per frame when idle, shifts it out LSB first.
//
// state      | meaning
// UART_IDLE  | line high, accepts next byte when valid_i
// UART_START | start bit (low) for CLKS_PER_BIT cycles
// UART_DATA  | eight data bits, LSB first
// UART_STOP  | stop bit (high), then back to idle
module uart_tx
  import periph_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       reset_ni,
  input  logic       valid_i,
  input  logic [7:0] data_i,
  output logic       ready_o,
  output logic       busy_o,
  output logic       tx_o
);

  localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);

  uart_state_e state, state_d;
  logic [15:0] baud_cnt, baud_d;
  logic [2:0]  bit_cnt, bit_d;
  logic [7:0]  shift, shift_d;

  always_ff @(posedge clk) begin
    if (!reset_ni) begin
      state    <= UART_IDLE;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shift    <= '0;
    end else begin
      state    <= state_d;
      baud_cnt <= baud_d;
      bit_cnt  <= bit_d;
      shift    <= shift_d;
    end
  end

  // baud_cnt counts down; reaching zero marks the last cycle of the current bit
  always_comb begin
    state_d = state;
    baud_d  = baud_cnt;
    bit_d   = bit_cnt;
    shift_d = shift;
    tx_o    = 1'b1;
    case (state)
      UART_IDLE: begin
        if (valid_i) begin
          shift_d = data_i;
          baud_d  = BAUD_LAST;
          bit_d   = '0;
          state_d = UART_START;
        end
      end
      UART_START: begin
        tx_o = 1'b0;
        if (baud_cnt == 16'd0) begin
          baud_d  = BAUD_LAST;
          state_d = UART_DATA;
        end else begin
          baud_d = baud_cnt - 16'd1;
        end
      end
      UART_DATA: begin
        tx_o = shift[0];
        if (baud_cnt == 16'd0) begin
          baud_d  = BAUD_LAST;
          shift_d = {1'b0, shift[7:1]};
          if (bit_cnt == 3'd7) state_d = UART_STOP;
          else                 bit_d   = bit_cnt + 3'd1;
        end else begin
          baud_d = baud_cnt - 16'd1;
        end
      end
      UART_STOP: begin
        if (baud_cnt == 16'd0) state_d = UART_IDLE;
        else                   baud_d  = baud_cnt - 16'd1;
      end
      default: state_d = UART_IDLE;
    endcase
  end

  assign ready_o = (state == UART_IDLE);
  assign busy_o  = (state != UART_IDLE);

endmodule

// File: rtl/mmio_periph.sv
// MMIO peripheral: display register, free-running timer, and a FIFO-fed UART transmitter.
module mmio_periph
  import periph_pkg::*;
#(
  parameter logic [19:0] BASE_HI      = 20'hF0000,
  parameter int          CLKS_PER_BIT = 868,
  parameter int          FIFO_DEPTH   = 4
) (
  input  logic        clk,
  input  logic        reset_ni,
  input  logic [31:0] addr_i,
  input  logic        we_i,
  input  logic [31:0] data_in_i,
  output logic [31:0] data_out_o,
  output logic [7:0]  display_o,
  output logic        tx_o
);

  localparam int             PW       = $clog2(FIFO_DEPTH);
  localparam logic [PW:0]    CNT_FULL = (PW + 1)'(FIFO_DEPTH);
  localparam logic [PW:0]    CNT_ONE  = (PW + 1)'(1);
  localparam logic [PW-1:0]  PTR_ONE  = PW'(1);

  logic          sel, wr;
  logic [11:0]   off;
  logic [7:0]    display;
  logic [31:0]   timer;
  logic [7:0]    mem [FIFO_DEPTH];
  logic [PW-1:0] wptr, rptr;
  logic [PW:0]   count;
  logic          overflow;
  logic          full, empty, push_req, push, pop, clr_ovf;
  logic          tx_ready, tx_busy;

  assign sel      = (addr_i[31:12] == BASE_HI);
  assign off      = addr_i[11:0];
  assign wr       = we_i && sel;
  assign full     = (count == CNT_FULL);
  assign empty    = (count == '0);
  assign push_req = wr && (off == OFF_UART_DATA);
  // full is judged before the transmitter's same-cycle pop, so a push at full is always dropped
  assign push     = push_req && !full;
  assign pop      = tx_ready && !empty;
  assign clr_ovf  = wr && (off == OFF_UART_STATUS) && data_in_i[STAT_OVERFLOW];

  always_ff @(posedge clk) begin
    if (!reset_ni) begin
      display  <= '0;
      timer    <= '0;
      wptr     <= '0;
      rptr     <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (wr && off == OFF_DISPLAY) display <= data_in_i[7:0];
      if (wr && off == OFF_TIMER) timer <= data_in_i;
      else                        timer <= timer + 32'd1;
      if (push) wptr <= wptr + PTR_ONE;
      if (pop)  rptr <= rptr + PTR_ONE;
      if (push && !pop)      count <= count + CNT_ONE;
      else if (pop && !push) count <= count - CNT_ONE;
      if (push_req && full) overflow <= 1'b1;
      else if (clr_ovf)     overflow <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= data_in_i[7:0];
  end

  uart_tx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tx (
    .clk      (clk),
    .reset_ni (reset_ni),
    .valid_i  (!empty),
    .data_i   (mem[rptr]),
    .ready_o  (tx_ready),
    .busy_o   (tx_busy),
    .tx_o     (tx_o)
  );

  always_comb begin
    data_out_o = '0;
    if (sel) begin
      case (off)
        OFF_DISPLAY: data_out_o = {24'h0, display};
        OFF_TIMER:   data_out_o = timer;
        OFF_UART_STATUS: begin
          data_out_o[STAT_FULL]     = full;
          data_out_o[STAT_EMPTY]    = empty;
          data_out_o[STAT_BUSY]     = tx_busy;
          data_out_o[STAT_OVERFLOW] = overflow;
        end
        default: data_out_o = '0;
      endcase
    end
  end

  assign display_o = display;

endmodule

// File: tb/tb_mmio_periph.sv
// Directed bench for mmio_periph with CLKS_PER_BIT=4, FIFO_DEPTH=4.
module tb_mmio_periph;

  logic        clk;
  logic        reset_ni;
  logic        we;
  logic [31:0] addr, wdata, rdata;
  logic [7:0]  disp;
  logic        tx;

  mmio_periph #(.BASE_HI(20'hF0000), .CLKS_PER_BIT(4), .FIFO_DEPTH(4)) dut (
    .clk        (clk),
    .reset_ni   (reset_ni),
    .addr_i     (addr),
    .we_i       (we),
    .data_in_i  (wdata),
    .data_out_o (rdata),
    .display_o  (disp),
    .tx_o       (tx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // {busy, tx} captured every falling edge
  logic [1:0] txlog[$];
  always @(negedge clk) txlog.push_back({dut.u_tx.busy_o, tx});

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    logic [31:0] raddr;
    logic [31:0] exp_rd;
    logic [7:0]  exp_disp;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] a, input logic w, input logic [31:0] d);
    addr  = a;
    we    = w;
    wdata = d;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d);
    addr = a;
    #1;
    d = rdata;
  endtask

  // expected {busy, tx} for sample k (0..39) of a frame carrying byte b
  function automatic logic [1:0] frame_sample(input logic [7:0] b, input int k);
    if (k < 4)       return 2'b10;
    else if (k < 36) return {1'b1, b[(k - 4) / 4]};
    else             return 2'b11;
  endfunction

  // idx is the sample of the pop cycle; each frame is one idle sample then 40 frame samples
  task automatic check_stream(input string name, input int idx, input int n,
                              input logic [7:0] bytes [5]);
    int bad;
    int base;
    if (txlog.size() < idx + 41 * n + 4)
      check({name, " log length"}, 32'(txlog.size()), 32'(idx + 41 * n + 4));
    for (int i = 0; i < n; i++) begin
      bad  = 0;
      base = idx + 41 * i;
      if (txlog[base] !== 2'b01) bad++;
      for (int k = 0; k < 40; k++)
        if (txlog[base + 1 + k] !== frame_sample(bytes[i], k)) bad++;
      check($sformatf("%s frame %0d bad samples", name, i), 32'(bad), 32'd0);
    end
    bad = 0;
    for (int k = 0; k < 4; k++)
      if (txlog[idx + 41 * n + k] !== 2'b01) bad++;
    check({name, " idle after"}, 32'(bad), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] r;
    logic [7:0]  b55   [5];
    logic [7:0]  burst [5];
    int idx;
    int bad;

    b55   = '{8'h55, 8'h00, 8'h00, 8'h00, 8'h00};
    burst = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};

    vecs[0] = '{32'hF0000000, 1'b1, 32'h000000A5, 32'hF0000000, 32'h000000A5, 8'hA5};
    vecs[1] = '{32'h00000000, 1'b1, 32'h12345678, 32'hF0000000, 32'h000000A5, 8'hA5};
    vecs[2] = '{32'hF0000010, 1'b1, 32'h0000003C, 32'hF0000010, 32'h00000000, 8'hA5};
    vecs[3] = '{32'hF0000008, 1'b0, 32'h00000000, 32'hF0000008, 32'h00000000, 8'hA5};
    vecs[4] = '{32'hF0001000, 1'b1, 32'h000000C3, 32'hF0000000, 32'h000000A5, 8'hA5};
    vecs[5] = '{32'hF0000000, 1'b1, 32'hFFFFFF00, 32'hF0000000, 32'h00000000, 8'h00};
    vecs[6] = '{32'hF000000C, 1'b1, 32'h00000000, 32'hF000000C, 32'h00000002, 8'h00};
    vecs[7] = '{32'hF0000000, 1'b1, 32'h0000005A, 32'hF0000000, 32'h0000005A, 8'h5A};
    vecs[8] = '{32'hF0000003, 1'b1, 32'h00000011, 32'hF0000003, 32'h00000000, 8'h5A};
    vecs[9] = '{32'h0000000C, 1'b0, 32'h00000000, 32'h0000000C, 32'h00000000, 8'h5A};

    reset_ni = 1'b0;
    drive(32'h0, 1'b0, 32'h0);
    repeat (3) @(posedge clk);
    step();
    reset_ni = 1'b1;
    rd(32'hF0000004, r); check("reset timer", r, 32'h0);
    rd(32'hF000000C, r); check("reset status", r, 32'h2);
    check("reset display", 32'(disp), 32'h0);
    check("reset tx", 32'(tx), 32'h1);

    for (int i = 0; i < 10; i++) begin
      step();
      drive(vecs[i].addr, vecs[i].we, vecs[i].wdata);
      step();
      we = 1'b0;
      rd(vecs[i].raddr, r);
      check($sformatf("vec %0d rdata", i), r, vecs[i].exp_rd);
      check($sformatf("vec %0d display", i), 32'(disp), 32'(vecs[i].exp_disp));
    end

    // timer load then wrap
    step();
    drive(32'hF0000004, 1'b1, 32'hFFFFFFFE);
    step();
    we = 1'b0;
    rd(32'hF0000004, r); check("timer loaded", r, 32'hFFFFFFFE);
    step();
    rd(32'hF0000004, r); check("timer +1", r, 32'hFFFFFFFF);
    step();
    rd(32'hF0000004, r); check("timer wrap", r, 32'h00000000);

    // single frame
    step();
    drive(32'hF0000008, 1'b1, 32'h55);
    step();
    we  = 1'b0;
    idx = txlog.size() - 1;
    repeat (46) step();
    check_stream("frame55", idx, 1, b55);

    // six pushes back-to-back: one popped, four queued, one dropped
    step();
    drive(32'hF0000008, 1'b1, 32'h11);
    step();
    idx = txlog.size() - 1;
    drive(32'hF0000008, 1'b1, 32'h22);
    step(); drive(32'hF0000008, 1'b1, 32'h33);
    step(); drive(32'hF0000008, 1'b1, 32'h44);
    step(); drive(32'hF0000008, 1'b1, 32'h55);
    step(); drive(32'hF0000008, 1'b1, 32'h66);
    step();
    we = 1'b0;
    rd(32'hF000000C, r); check("status full+ovf", r, 32'hD);
    drive(32'hF000000C, 1'b1, 32'h8);
    step();
    we = 1'b0;
    rd(32'hF000000C, r); check("status ovf cleared", r, 32'h5);
    repeat (5 * 41 + 10) step();
    check_stream("burst", idx, 5, burst);
    rd(32'hF000000C, r); check("status after burst", r, 32'h2);

    // reset during data bit 3 of 0xF0 with two bytes queued
    drive(32'hF0000000, 1'b1, 32'h77);
    step(); drive(32'hF0000008, 1'b1, 32'hF0);
    step();
    drive(32'hF0000008, 1'b1, 32'hAA);
    step(); drive(32'hF0000008, 1'b1, 32'h33);
    step();
    we = 1'b0;
    repeat (15) step();
    check("data bit3 before reset", 32'(txlog[txlog.size() - 1]), 32'h2);
    reset_ni = 1'b0;
    drive(32'hF0000000, 1'b1, 32'h99);
    step();
    reset_ni = 1'b1;
    we = 1'b0;
    check("tx after reset", 32'(tx), 32'h1);
    check("display after reset", 32'(disp), 32'h0);
    rd(32'hF000000C, r); check("status after reset", r, 32'h2);
    rd(32'hF0000004, r); check("timer after reset", r, 32'h0);
    repeat (50) step();
    bad = 0;
    for (int k = txlog.size() - 50; k < txlog.size(); k++)
      if (txlog[k] !== 2'b01) bad++;
    check("line idle after reset", 32'(bad), 32'h0);
    rd(32'hF000000C, r); check("queue discarded", r, 32'h2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
